reg_write_demux: RTL and testbench

//   Write-side counterpart of the register-file read mux. Accepts one write request
//   per cycle (addr, data), decodes the 5-bit address to a one-hot 32-bit write enable,
//   and registers enable+data for the register array.

---
 rtl/reg_write_demux_pkg.sv | 13 +
 rtl/reg_write_demux_if.sv | 29 ++
 rtl/reg_write_demux_decoder_5to32.sv | 17 +
 rtl/reg_write_demux.sv | 66 ++++++
 tb/tb_reg_write_demux.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/reg_write_demux_pkg.sv
// Shared constants and the 4:16 decode helper for the register-file write path.
package reg_write_demux_pkg;

  localparam int NUM_REGS     = 32;
  localparam int ADDR_W       = 5;
  localparam int DEF_ZERO_REG = 31;
  localparam int DEF_WIDTH    = 64;

  function automatic logic [15:0] dec4to16(input logic en, input logic [3:0] a);
    return en ? (16'd1 << a) : 16'd0;
  endfunction

endpackage

// File: rtl/reg_write_demux_if.sv
// Writeback/reservation bus between decode/writeback and the write demux.
interface reg_write_demux_if
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                rsv_valid;
  logic [ADDR_W-1:0]   rsv_addr;
  logic                rsv_ready;
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_ready;
  logic [NUM_REGS-1:0] we;
  logic [WIDTH-1:0]    we_data;
  logic [NUM_REGS-1:0] busy;

  modport master (
    output rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
    input  rsv_ready, wr_ready, we, we_data, busy
  );

  modport slave (
    input  rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
    output rsv_ready, wr_ready, we, we_data, busy
  );

endinterface

// File: rtl/reg_write_demux_decoder_5to32.sv
// Combinational 5:32 one-hot decoder, split into two 4:16 halves selected by addr[4].
module decoder_5to32
  import reg_write_demux_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  logic en_hi;
  logic en_lo;

  assign en_hi  = en & addr[4];
  assign en_lo  = en & ~addr[4];
  assign onehot = {dec4to16(en_hi, addr[3:0]), dec4to16(en_lo, addr[3:0])};

endmodule

// File: rtl/reg_write_demux.sv
// Register-file write demux: one-hot write enable, aligned data, and a pending-write scoreboard.
module reg_write_demux
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                clk,
  input  logic                reset_n,
  reg_write_demux_if.slave    bus
);

  localparam logic [NUM_REGS-1:0] LIVE_MASK = ~(NUM_REGS'(1) << ZERO_REG);

  logic [NUM_REGS-1:0] wr_hit_p0;
  logic [NUM_REGS-1:0] rsv_hit_p0;
  logic [NUM_REGS-1:0] we_nxt_p0;
  logic [NUM_REGS-1:0] busy_nxt_p0;
  logic                rsv_ok_p0;
  logic                retire_same_p0;

  logic [NUM_REGS-1:0] we_p1;
  logic [WIDTH-1:0]    we_data_p1;
  logic [NUM_REGS-1:0] busy_p1;

  decoder_5to32 u_wr_dec (
    .en     (bus.wr_valid),
    .addr   (bus.wr_addr),
    .onehot (wr_hit_p0)
  );

  decoder_5to32 u_rsv_dec (
    .en     (bus.rsv_valid & rsv_ok_p0),
    .addr   (bus.rsv_addr),
    .onehot (rsv_hit_p0)
  );

  // A reservation may overtake an outstanding write only if that write retires this cycle.
  assign retire_same_p0 = bus.wr_valid & (bus.wr_addr == bus.rsv_addr);
  assign rsv_ok_p0      = ~(busy_p1[bus.rsv_addr] & ~retire_same_p0);

  assign we_nxt_p0   = wr_hit_p0 & LIVE_MASK;
  assign busy_nxt_p0 = (busy_p1 & ~wr_hit_p0) | (rsv_hit_p0 & LIVE_MASK);

  // ---- stage p0 -> p1 boundary ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_p1      <= '0;
      we_data_p1 <= '0;
      busy_p1    <= '0;
    end else begin
      we_p1   <= we_nxt_p0;
      busy_p1 <= busy_nxt_p0;
      if (|we_nxt_p0) begin
        we_data_p1 <= bus.wr_data;
      end
    end
  end

  assign bus.wr_ready  = 1'b1;
  assign bus.rsv_ready = rsv_ok_p0;
  assign bus.we        = we_p1;
  assign bus.we_data   = we_data_p1;
  assign bus.busy      = busy_p1;

endmodule

// File: tb/tb_reg_write_demux.sv
// Directed and model-checked stimulus for reg_write_demux.
module tb_reg_write_demux;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  reg_write_demux_if #(.WIDTH(64)) bus ();

  reg_write_demux #(.WIDTH(64), .ZERO_REG(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mbusy;
  logic [31:0] mwe;
  logic [63:0] mdata;
  logic [31:0] clr;
  logic [31:0] set;
  logic        rv, wv, exp_rr;
  logic [4:0]  ra, wa;
  logic [63:0] wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
  endtask

  initial begin
    idle_inputs();

    // Reset asserted mid-cycle takes effect immediately
    #7 reset_n = 1'b0;
    #1;
    chk("rst_we", 64'(bus.we), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_we_data", bus.we_data, 64'h0);
    chk("wr_ready", 64'(bus.wr_ready), 64'h1);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_we", 64'(bus.we), 64'h0);
    end

    // Single write to X5
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hDEAD_BEEF;
    step();
    chk("wr5_we", 64'(bus.we), 64'h20);
    chk("wr5_data", bus.we_data, 64'hDEAD_BEEF);
    idle_inputs();
    step();
    chk("wr5_we_off", 64'(bus.we), 64'h0);
    chk("wr5_data_hold", bus.we_data, 64'hDEAD_BEEF);

    // Zero register is never written nor reserved
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 64'h1234;
    step();
    chk("wr31_we", 64'(bus.we), 64'h0);
    chk("wr31_busy", 64'(bus.busy), 64'h0);
    idle_inputs();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd31;
    #1;
    chk("rsv31_ready", 64'(bus.rsv_ready), 64'h1);
    step();
    chk("rsv31_busy", 64'(bus.busy), 64'h0);
    idle_inputs();

    // WAW stall on X7, then same-cycle retire + re-reserve
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
    #1;
    chk("rsv7_ready1", 64'(bus.rsv_ready), 64'h1);
    step();
    chk("rsv7_busy1", 64'(bus.busy), 64'h80);
    #1;
    chk("rsv7_ready2", 64'(bus.rsv_ready), 64'h0);
    step();
    chk("rsv7_busy2", 64'(bus.busy), 64'h80);
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h77;
    #1;
    chk("rsv7_retire_ready", 64'(bus.rsv_ready), 64'h1);
    step();
    chk("rsv7_retire_busy", 64'(bus.busy), 64'h80);
    chk("rsv7_retire_we", 64'(bus.we), 64'h80);
    idle_inputs();
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h78;
    step();
    chk("wr7_clear_busy", 64'(bus.busy), 64'h0);
    idle_inputs();

    // Back-to-back sweep over every writable register
    for (int k = 0; k < 31; k++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 5'(k); bus.wr_data = 64'(k) + 64'hA000;
      step();
      chk("sweep_we", 64'(bus.we), 64'(32'd1 << k));
      chk("sweep_data", bus.we_data, 64'(k) + 64'hA000);
      chk("sweep_onehot0", 64'($countones(bus.we) <= 1), 64'h1);
    end
    idle_inputs();
    step();
    chk("sweep_end_we", 64'(bus.we), 64'h0);

    // Random reservation/writeback traffic against a reference scoreboard
    mbusy = '0;
    mdata = bus.we_data;
    for (int c = 0; c < 3000; c++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      wv = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      bus.rsv_valid = rv; bus.rsv_addr = ra;
      bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
      #1;
      exp_rr = !(mbusy[ra] && !(wv && wa == ra));
      chk("rand_rsv_ready", 64'(bus.rsv_ready), 64'(exp_rr));
      clr = wv ? (32'd1 << wa) : 32'd0;
      set = (rv && exp_rr && ra != 5'd31) ? (32'd1 << ra) : 32'd0;
      mbusy = (mbusy & ~clr) | set;
      mwe = (wv && wa != 5'd31) ? (32'd1 << wa) : 32'd0;
      if (mwe != 0) mdata = wd;
      step();
      chk("rand_busy", 64'(bus.busy), 64'(mbusy));
      chk("rand_we", 64'(bus.we), 64'(mwe));
      chk("rand_onehot0", 64'($countones(bus.we) <= 1), 64'h1);
      if (mwe != 0) chk("rand_data", bus.we_data, mdata);
    end
    idle_inputs();

    // Reset in the middle of activity drops pending state at once
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 64'h55;
    step();
    idle_inputs();
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_we", 64'(bus.we), 64'h0);
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    chk("midrst_data", bus.we_data, 64'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_we", 64'(bus.we), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
